// File: rtl/mouse_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// mouse_cmd_arbiter_if
//
// Bundles every handshake and byte-bus signal around the mouse command
// arbiter: the two requester channels, the transmitter/receiver byte
// interfaces and the completion report.
//
// Signals:
//   req0_valid / req1_valid  requester command request (held until ready)
//   req0_byte  / req1_byte   requester command byte
//   req0_ready / req1_ready  one-cycle grant pulse back to the requester
//   send_byte                one-cycle start pulse to the transmitter
//   byte_to_send             captured command byte for the transmitter
//   byte_sent                transmitter completion pulse
//   read_enable              receiver enable
//   byte_read                received byte
//   byte_error_code          receiver error code, non-zero = corrupted byte
//   byte_ready               receiver byte-valid pulse
//   done                     one-cycle completion pulse
//   done_id                  requester owning the finished command
//   done_status              completion status (ack/resend/error/timeout)
//   busy                     arbiter is handling a command
//
// Modports:
//   slave   the arbiter itself
//   master  the surroundings (requesters, transmitter, receiver)
// ---------------------------------------------------------------------------
interface mouse_cmd_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_byte;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_byte;
    logic       req1_ready;
    logic       send_byte;
    logic [7:0] byte_to_send;
    logic       byte_sent;
    logic       read_enable;
    logic [7:0] byte_read;
    logic [1:0] byte_error_code;
    logic       byte_ready;
    logic       done;
    logic       done_id;
    logic [1:0] done_status;
    logic       busy;

    modport slave (
        input  req0_valid,
        input  req0_byte,
        input  req1_valid,
        input  req1_byte,
        input  byte_sent,
        input  byte_read,
        input  byte_error_code,
        input  byte_ready,
        output req0_ready,
        output req1_ready,
        output send_byte,
        output byte_to_send,
        output read_enable,
        output done,
        output done_id,
        output done_status,
        output busy
    );

    modport master (
        output req0_valid,
        output req0_byte,
        output req1_valid,
        output req1_byte,
        output byte_sent,
        output byte_read,
        output byte_error_code,
        output byte_ready,
        input  req0_ready,
        input  req1_ready,
        input  send_byte,
        input  byte_to_send,
        input  read_enable,
        input  done,
        input  done_id,
        input  done_status,
        input  busy
    );
endinterface

// File: rtl/mouse_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// mouse_cmd_arbiter
//
// Shares the PS/2 mouse transmitter and receiver between two command
// requesters (0 = power-up initialisation sequencer, 1 = processor bus
// peripheral). One requester is granted at a time; its byte is sent, the
// mouse acknowledge is collected, resend replies are retried up to
// MAX_RETRIES times and exactly one completion status is reported per
// command.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed from entering WAIT_SENT to the end of
//                   WAIT_ACK for one attempt (2 .. 2^24-1)
//   MAX_RETRIES     resend attempts allowed after the first send
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mouse_cmd_arbiter_if.slave (requesters, tx/rx bytes, status)
//
// Status encoding: 00 ack (0xFA), 01 resend retries exhausted,
//                  10 error (0xFC), 11 timeout.
// ---------------------------------------------------------------------------
module mouse_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mouse_cmd_arbiter_if.slave bus
);

    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);
    localparam logic [23:0]        TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] ACK_BYTE    = 8'hFA;
    localparam logic [7:0] ERROR_BYTE  = 8'hFC;
    localparam logic [7:0] RESEND_BYTE = 8'hFE;

    localparam logic [1:0] STATUS_ACK     = 2'b00;
    localparam logic [1:0] STATUS_RETRIES = 2'b01;
    localparam logic [1:0] STATUS_ERROR   = 2'b10;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_SENT,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [RETRY_W-1:0]   retry_count;
    logic [23:0]          timer;
    logic                 owner;
    logic                 last_grant;
    logic [7:0]           byte_reg;
    logic                 done_id_reg;
    logic [1:0]           done_status_reg;

    logic                 grant;
    logic                 grant_id;
    logic                 retry;
    logic                 finish;
    logic [1:0]           finish_status;
    logic                 timed_out;
    logic                 reply_bad;

    // The attempt timer starts at zero in the first WAIT_SENT cycle, so it
    // equals TIMEOUT_CYCLES-1 in the last allowed cycle. ">=" covers a
    // BYTE_SENT arriving in that very cycle, which pushes the timer one past.
    assign timed_out = (timer >= TIMEOUT_LAST);

    // A corrupted byte is treated exactly like an explicit resend request.
    assign reply_bad = (bus.byte_error_code != 2'b00) || (bus.byte_read == RESEND_BYTE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the one-cycle control strobes that the datapath
    // below consumes (grant, retry, finish with its status).
    always_comb begin
        state_next    = state;
        grant         = 1'b0;
        grant_id      = 1'b0;
        retry         = 1'b0;
        finish        = 1'b0;
        finish_status = STATUS_ACK;

        case (state)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    grant = 1'b1;
                    // Round-robin only matters under contention: the side
                    // not granted last wins.
                    if (bus.req0_valid && bus.req1_valid) begin
                        grant_id = ~last_grant;
                    end else begin
                        grant_id = bus.req1_valid;
                    end
                    state_next = S_SEND;
                end
            end

            S_SEND: begin
                state_next = S_WAIT_SENT;
            end

            S_WAIT_SENT: begin
                if (bus.byte_sent) begin
                    state_next = S_WAIT_ACK;
                end else if (timed_out) begin
                    finish        = 1'b1;
                    finish_status = STATUS_TIMEOUT;
                end
            end

            S_WAIT_ACK: begin
                // A reply in the final cycle beats the timeout.
                if (bus.byte_ready) begin
                    if (reply_bad) begin
                        if (retry_count < RETRY_LIMIT) begin
                            retry      = 1'b1;
                            state_next = S_SEND;
                        end else begin
                            finish        = 1'b1;
                            finish_status = STATUS_RETRIES;
                        end
                    end else if (bus.byte_read == ACK_BYTE) begin
                        finish        = 1'b1;
                        finish_status = STATUS_ACK;
                    end else if (bus.byte_read == ERROR_BYTE) begin
                        finish        = 1'b1;
                        finish_status = STATUS_ERROR;
                    end else if (timed_out) begin
                        finish        = 1'b1;
                        finish_status = STATUS_TIMEOUT;
                    end
                end else if (timed_out) begin
                    finish        = 1'b1;
                    finish_status = STATUS_TIMEOUT;
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (finish) begin
            state_next = S_DONE;
        end
    end

    // Transaction datapath: captured byte, owner, retry count, attempt timer,
    // completion report and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_reg        <= 8'h00;
            owner           <= 1'b0;
            retry_count     <= '0;
            timer           <= 24'd0;
            done_id_reg     <= 1'b0;
            done_status_reg <= STATUS_ACK;
            last_grant      <= 1'b1;
        end else begin
            if (grant) begin
                byte_reg    <= grant_id ? bus.req1_byte : bus.req0_byte;
                owner       <= grant_id;
                retry_count <= '0;
            end else if (retry) begin
                retry_count <= retry_count + RETRY_ONE;
            end

            if (state == S_SEND) begin
                timer <= 24'd0;
            end else if ((state == S_WAIT_SENT) || (state == S_WAIT_ACK)) begin
                timer <= timer + 24'd1;
            end

            // Report is loaded on the edge into DONE so it is already valid
            // while the DONE pulse is high, then held until the next one.
            if (finish) begin
                done_id_reg     <= owner;
                done_status_reg <= finish_status;
            end

            if (state == S_DONE) begin
                last_grant <= owner;
            end
        end
    end

    // READY goes only with the first send of a transaction; retries leave
    // the retry count non-zero, which suppresses it.
    assign bus.req0_ready   = (state == S_SEND) && (retry_count == '0) && !owner;
    assign bus.req1_ready   = (state == S_SEND) && (retry_count == '0) && owner;
    assign bus.send_byte    = (state == S_SEND);
    assign bus.read_enable  = (state == S_WAIT_SENT) || (state == S_WAIT_ACK);
    assign bus.done         = (state == S_DONE);
    assign bus.busy         = (state != S_IDLE);
    assign bus.byte_to_send = byte_reg;
    assign bus.done_id      = done_id_reg;
    assign bus.done_status  = done_status_reg;

endmodule

// File: tb/tb_mouse_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mouse_cmd_arbiter
//
// Self-checking bench for mouse_cmd_arbiter (TIMEOUT_CYCLES=100,
// MAX_RETRIES=3). Each command is described as a per-attempt reply script
// (when BYTE_SENT arrives, when and what the mouse replies, plus ignored
// stray traffic). A transaction-level predictor turns the script into the
// expected number of sends, final status and DONE cycle; the driver then
// plays the script cycle by cycle and checks the DUT against it.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mouse_cmd_arbiter;

    localparam int T     = 100;
    localparam int MR    = 3;
    localparam int NEVER = 1000;

    logic clk;
    logic rst_n;

    mouse_cmd_arbiter_if bus ();

    mouse_cmd_arbiter #(
        .TIMEOUT_CYCLES(T),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reply script, one entry per attempt.
    int         sent_at   [0:MR];
    int         reply_at  [0:MR];
    logic [7:0] reply_byte[0:MR];
    logic [1:0] reply_err [0:MR];
    int         noise_at  [0:MR];
    logic [7:0] noise_byte[0:MR];
    int         stray_at  [0:MR];
    int         ghost_at  [0:MR];
    bit         send_ghost;

    // Round-robin memory of the reference model.
    bit last_grant;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input bit v0, input bit v1,
                                  input logic [7:0] b0, input logic [7:0] b1);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_byte  = b0;
        bus.req1_byte  = b1;
    endtask

    task automatic clear_script();
        for (int a = 0; a <= MR; a++) begin
            sent_at[a]    = NEVER;
            reply_at[a]   = NEVER;
            reply_byte[a] = 8'h00;
            reply_err[a]  = 2'b00;
            noise_at[a]   = -1;
            noise_byte[a] = 8'h00;
            stray_at[a]   = -1;
            ghost_at[a]   = -1;
        end
        send_ghost = 1'b0;
    endtask

    task automatic set_attempt(input int a, input int s, input int r,
                               input logic [7:0] b, input logic [1:0] e);
        sent_at[a]    = s;
        reply_at[a]   = r;
        reply_byte[a] = b;
        reply_err[a]  = e;
    endtask

    task automatic random_script();
        int k;
        clear_script();
        for (int a = 0; a <= MR; a++) begin
            sent_at[a]  = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 30));
            reply_at[a] = ($urandom_range(0, 11) == 0) ? NEVER
                                                       : sent_at[a] + int'($urandom_range(1, 40));
            k = int'($urandom_range(0, 3));
            case (k)
                0:       set_attempt(a, sent_at[a], reply_at[a], 8'hFA, 2'b00);
                1:       set_attempt(a, sent_at[a], reply_at[a], 8'hFC, 2'b00);
                2:       set_attempt(a, sent_at[a], reply_at[a], 8'hFE, 2'b00);
                default: set_attempt(a, sent_at[a], reply_at[a], 8'($urandom_range(0, 255)),
                                     2'($urandom_range(1, 3)));
            endcase
            if (sent_at[a] < NEVER && $urandom_range(0, 1) == 1) begin
                noise_at[a]   = sent_at[a] + int'($urandom_range(1, 40));
                noise_byte[a] = 8'($urandom_range(0, 255));
                if (noise_byte[a] == 8'hFA || noise_byte[a] == 8'hFC || noise_byte[a] == 8'hFE)
                    noise_byte[a] = 8'h55;
            end
            if (sent_at[a] > 0 && $urandom_range(0, 1) == 1) begin
                stray_at[a] = (sent_at[a] == NEVER) ? int'($urandom_range(0, 30))
                                                    : int'($urandom_range(0, sent_at[a] - 1));
            end
            if (sent_at[a] < NEVER && $urandom_range(0, 1) == 1)
                ghost_at[a] = sent_at[a] + int'($urandom_range(1, 5));
        end
        send_ghost = 1'($urandom_range(0, 1));
    endtask

    // Outcome of a command from its reply script: an attempt times out if
    // the transmitter never finishes in time or no decisive reply arrives
    // by cycle T-1 of the attempt; resend/corrupt replies consume retries.
    function automatic void predict(output int n_att, output logic [1:0] st,
                                    output int done_j);
        n_att  = 0;
        st     = 2'b11;
        done_j = T;
        for (int a = 0; a <= MR; a++) begin
            n_att = a + 1;
            if (sent_at[a] > T - 2 || reply_at[a] > T - 1) begin
                st     = 2'b11;
                done_j = T;
                return;
            end
            done_j = reply_at[a] + 1;
            if (reply_err[a] != 2'b00 || reply_byte[a] == 8'hFE) begin
                if (a == MR) begin
                    st = 2'b01;
                    return;
                end
            end else begin
                st = (reply_byte[a] == 8'hFA) ? 2'b00 : 2'b10;
                return;
            end
        end
    endfunction

    // Runs one complete command starting at a falling edge where the DUT is
    // idle; returns at the falling edge of the idle cycle after DONE.
    task automatic run_command(input string name, input bit v0, input bit v1,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input bit keep_other);
        bit         owner;
        bit         last;
        logic [7:0] exp_byte;
        logic [1:0] exp_st;
        int         n_att;
        int         done_j;
        int         end_j;
        int         sends;
        int         readies;

        check_output({name, "_idle_busy"}, bus.busy, 1'b0);
        apply_stimulus(v0, v1, b0, b1);
        owner    = (v0 && v1) ? ~last_grant : v1;
        exp_byte = owner ? b1 : b0;
        predict(n_att, exp_st, done_j);
        sends   = 0;
        readies = 0;

        @(negedge clk);
        sends   += int'(bus.send_byte);
        readies += int'(bus.req0_ready) + int'(bus.req1_ready);
        check_output({name, "_send_byte"}, bus.send_byte, 1'b1);
        check_output({name, "_ready0"}, bus.req0_ready, !owner);
        check_output({name, "_ready1"}, bus.req1_ready, owner);
        check_output({name, "_byte_to_send"}, bus.byte_to_send, exp_byte);
        if (owner) bus.req1_valid = 1'b0;
        else       bus.req0_valid = 1'b0;
        if (!keep_other) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        bus.byte_sent = send_ghost;

        for (int a = 0; a < n_att; a++) begin
            last  = (a == n_att - 1);
            end_j = last ? done_j : reply_at[a] + 1;
            for (int j = 0; j <= end_j; j++) begin
                @(negedge clk);
                sends   += int'(bus.send_byte);
                readies += int'(bus.req0_ready) + int'(bus.req1_ready);
                if (j == end_j && last) begin
                    check_output({name, "_done"}, bus.done, 1'b1);
                    check_output({name, "_done_id"}, bus.done_id, owner);
                    check_output({name, "_done_status"}, bus.done_status, exp_st);
                    check_output({name, "_done_rden"}, bus.read_enable, 1'b0);
                    check_output({name, "_done_byte"}, bus.byte_to_send, exp_byte);
                end else if (j == end_j) begin
                    check_output({name, "_retry_send"}, bus.send_byte, 1'b1);
                    check_output({name, "_retry_ready"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
                end else begin
                    check_output({name, "_wait_rden"}, bus.read_enable, 1'b1);
                    check_output({name, "_wait_done"}, bus.done, 1'b0);
                    check_output({name, "_wait_send"}, bus.send_byte, 1'b0);
                end

                bus.byte_sent       = 1'b0;
                bus.byte_ready      = 1'b0;
                bus.byte_read       = 8'h00;
                bus.byte_error_code = 2'b00;
                if (j < end_j) begin
                    if (j == sent_at[a] || j == ghost_at[a]) bus.byte_sent = 1'b1;
                    if (j == reply_at[a]) begin
                        bus.byte_ready      = 1'b1;
                        bus.byte_read       = reply_byte[a];
                        bus.byte_error_code = reply_err[a];
                    end else if (j == noise_at[a]) begin
                        bus.byte_ready = 1'b1;
                        bus.byte_read  = noise_byte[a];
                    end else if (j == stray_at[a]) begin
                        bus.byte_ready = 1'b1;
                        bus.byte_read  = 8'hFA;
                    end
                end else if (!last) begin
                    bus.byte_sent = send_ghost;
                end
            end
        end

        check_output({name, "_send_count"}, sends, n_att);
        check_output({name, "_ready_count"}, readies, 1);
        last_grant = owner;

        @(negedge clk);
        check_output({name, "_after_busy"}, bus.busy, 1'b0);
        check_output({name, "_after_done"}, bus.done, 1'b0);
        check_output({name, "_held_id"}, bus.done_id, owner);
        check_output({name, "_held_status"}, bus.done_status, exp_st);
    endtask

    // Hard stop in case the bench itself loses track of the DUT.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] v;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00);
        bus.byte_sent       = 1'b0;
        bus.byte_ready      = 1'b0;
        bus.byte_read       = 8'h00;
        bus.byte_error_code = 2'b00;
        last_grant = 1'b1;

        repeat (3) @(negedge clk);
        check_output("rst_busy", bus.busy, 1'b0);
        check_output("rst_send", bus.send_byte, 1'b0);
        check_output("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        check_output("rst_rden", bus.read_enable, 1'b0);
        check_output("rst_done", bus.done, 1'b0);
        check_output("rst_byte", bus.byte_to_send, 8'h00);
        check_output("rst_done_id", bus.done_id, 1'b0);
        check_output("rst_status", bus.done_status, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention straight from reset, then a second simultaneous pair.
        clear_script();
        set_attempt(0, 3, 8, 8'hFA, 2'b00);
        run_command("pair_a", 1'b1, 1'b1, 8'hFF, 8'hE8, 1'b1);
        run_command("pair_b", 1'b1, 1'b1, 8'h11, 8'hE8, 1'b1);
        run_command("pair_c", 1'b1, 1'b0, 8'h11, 8'h00, 1'b0);

        clear_script();
        set_attempt(0, 20, 24, 8'hFA, 2'b00);
        run_command("req1_f4", 1'b0, 1'b1, 8'h00, 8'hF4, 1'b0);

        clear_script();
        for (int a = 0; a <= MR; a++) set_attempt(a, 2, 5, 8'hFE, 2'b00);
        run_command("fe_x4", 1'b1, 1'b0, 8'hF3, 8'h00, 1'b0);

        clear_script();
        set_attempt(0, 2, 5, 8'hFE, 2'b00);
        set_attempt(1, 1, 3, 8'hFE, 2'b00);
        set_attempt(2, 4, 9, 8'hFA, 2'b00);
        run_command("fe_fe_fa", 1'b0, 1'b1, 8'h00, 8'hF2, 1'b0);

        clear_script();
        set_attempt(0, 3, 9, 8'hFC, 2'b00);
        noise_at[0]   = 6;
        noise_byte[0] = 8'h08;
        run_command("noise_fc", 1'b1, 1'b0, 8'hE6, 8'h00, 1'b0);

        clear_script();
        set_attempt(0, 3, 7, 8'hFA, 2'b01);
        set_attempt(1, 4, 8, 8'hFA, 2'b00);
        run_command("err_resend", 1'b1, 1'b0, 8'hE7, 8'h00, 1'b0);

        clear_script();
        run_command("tmo_sent", 1'b1, 1'b0, 8'hF0, 8'h00, 1'b0);

        clear_script();
        set_attempt(0, 10, 99, 8'hFA, 2'b00);
        run_command("tmo_tie", 1'b0, 1'b1, 8'h00, 8'hF5, 1'b0);

        clear_script();
        set_attempt(0, 10, NEVER, 8'hFA, 2'b00);
        run_command("tmo_ack", 1'b1, 1'b0, 8'hEA, 8'h00, 1'b0);

        // Leave a non-reset report behind, then reset during WAIT_ACK.
        clear_script();
        set_attempt(0, 2, 6, 8'hFC, 2'b00);
        run_command("pre_reset", 1'b0, 1'b1, 8'h00, 8'hEB, 1'b0);

        apply_stimulus(1'b1, 1'b0, 8'hF3, 8'h00);
        @(negedge clk);
        check_output("rstmid_send", bus.send_byte, 1'b1);
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        bus.byte_sent = 1'b1;
        @(negedge clk);
        bus.byte_sent = 1'b0;
        check_output("rstmid_rden", bus.read_enable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_output("rstmid_busy", bus.busy, 1'b0);
        check_output("rstmid_rden0", bus.read_enable, 1'b0);
        check_output("rstmid_byte", bus.byte_to_send, 8'h00);
        check_output("rstmid_done_id", bus.done_id, 1'b0);
        check_output("rstmid_status", bus.done_status, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("rstmid_no_done", bus.done, 1'b0);
        end
        rst_n      = 1'b1;
        last_grant = 1'b1;

        clear_script();
        set_attempt(0, 4, 9, 8'hFA, 2'b00);
        run_command("post_reset", 1'b1, 1'b0, 8'hF4, 8'h00, 1'b0);

        // Randomised commands.
        for (int n = 0; n < 30; n++) begin
            v = 2'($urandom_range(1, 3));
            random_script();
            run_command("rand", v[0], v[1], 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)), 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(negedge clk);
                check_output("rand_gap_busy", bus.busy, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mouse_cmd_arbiter.md
# mouse_cmd_arbiter

Shares the PS/2 mouse transmitter/receiver byte interfaces between two command requesters: the power-up initialisation sequencer (requester 0) and the processor bus peripheral (requester 1). The block grants one requester at a time, sends its command byte, collects the mouse acknowledge, retries on resend (0xFE) and reports one completion status per command. It sits between the requesters and the mouse transmitter/receiver inside the mouse subsystem.

## Interface
- TIMEOUT_CYCLES, 2000000: max cycles allowed in WAIT_SENT plus WAIT_ACK per attempt (20 ms at 100 MHz); legal range 2 to 2^24-1.
- MAX_RETRIES, 3: resend attempts after the first send before reporting failure.
- CLK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ0_VALID / REQ1_VALID  in  1  command request; held high until the matching READY pulse.
- REQ0_BYTE / REQ1_BYTE  in  8  command byte; stable while VALID is high.
- REQ0_READY / REQ1_READY  out  1  one-cycle grant pulse; byte captured.
- SEND_BYTE  out  1  one-cycle pulse to the transmitter.
- BYTE_TO_SEND  out  8  captured command byte, held for the whole transaction.
- BYTE_SENT  in  1  transmitter completion pulse.
- READ_ENABLE  out  1  receiver enable.
- BYTE_READ  in  8  received byte.
- BYTE_ERROR_CODE  in  2  receiver error; non-zero means a corrupted byte.
- BYTE_READY  in  1  receiver byte-valid pulse.
- DONE  out  1  one-cycle completion pulse.
- DONE_ID  out  1  requester that owned the finished command; valid with DONE, held until the next DONE.
- DONE_STATUS  out  2  00 ack (0xFA); 01 resend retries exhausted; 10 error (0xFC); 11 timeout. Valid with DONE, held until the next DONE.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SEND, WAIT_SENT, WAIT_ACK, DONE.
- IDLE:
  - With no VALID high, stay in IDLE.
  - With either VALID high, arbitrate.
    - Only one VALID high: grant it.
    - Both high: grant the requester not granted last (round-robin). The last-grant pointer resets to 1, so requester 0 wins the first contention.
  - On grant: capture the byte into BYTE_TO_SEND, record the owner, clear the retry count, go to SEND.
- SEND:
  - SEND_BYTE=1 for exactly one cycle.
  - The owner's READY=1 in the first SEND cycle of the transaction only; no READY on retries.
  - Clear the timeout counter, go to WAIT_SENT.
- WAIT_SENT:
  - READ_ENABLE=1 and the counter increments.
  - BYTE_SENT: go to WAIT_ACK; the counter keeps running.
  - Counter reaching TIMEOUT_CYCLES-1 without BYTE_SENT: status 11.
- WAIT_ACK, READ_ENABLE=1, on BYTE_READY:
  - BYTE_ERROR_CODE≠0 or BYTE_READ=0xFE: if retry count < MAX_RETRIES, increment it and go to SEND; otherwise status 01.
  - 0xFA: status 00.
  - 0xFC: status 10.
  - Any other byte: ignored; stay in WAIT_ACK and the counter keeps running.
- WAIT_ACK timeout: counter reaching TIMEOUT_CYCLES-1 gives status 11. Timeouts are never retried.
- DONE:
  - DONE=1 for one cycle; DONE_ID and DONE_STATUS are updated in the same cycle.
  - Update the last-grant pointer, return to IDLE.
- A VALID that drops before its READY is legal; the request is withdrawn and not queued.

## Timing
- Reset values: all 1-bit outputs 0, BYTE_TO_SEND=0x00, DONE_ID=0, DONE_STATUS=00. Internal state: IDLE, retry count 0, counter 0, pointer 1.
- Reset mid-transaction: immediate return to IDLE with no DONE; the command is abandoned.
- VALID sampled in IDLE at edge n: READY and SEND_BYTE both high in cycle n+1; WAIT_SENT from n+2.
- BYTE_SENT at cycle k: WAIT_ACK from k+1.
- BYTE_READY at cycle m: DONE at m+1, IDLE at m+2. Earliest next READY is m+3, so there is one idle cycle between transactions.
- BYTE_READY and timeout in the same cycle: BYTE_READY wins.
- BYTE_SENT during SEND, or in WAIT_ACK: ignored.
- BYTE_READY during WAIT_SENT: ignored.
- Retry path: BYTE_READY(0xFE) at m puts SEND at m+1; the counter restarts at 0.
- Counter width: 24 bits; it never wraps because the timeout fires first.

## Test plan
- TIMEOUT_CYCLES=100.
  - REQ1 sends 0xF4; BYTE_SENT 20 cycles later; BYTE_READY with 0xFA.
  - Required: REQ1_READY and SEND_BYTE pulse together; BYTE_TO_SEND=0xF4; DONE one cycle after BYTE_READY; DONE_ID=1, DONE_STATUS=00.
- REQ0=0xFF and REQ1=0xE8 raised in the same cycle from reset.
  - Required: REQ0 is granted first and REQ1 is granted after the first DONE. A second simultaneous pair is granted to REQ1 first.
- Mouse answers 0xFE four times, MAX_RETRIES=3.
  - Required: four SEND_BYTE pulses, one READY pulse, then DONE_STATUS=01.
  - Repeat with 0xFE, 0xFE, 0xFA: required three SEND_BYTE pulses, then status 00.
- Bytes 0x08 then 0xFC in WAIT_ACK.
  - Required: 0x08 is ignored; DONE_STATUS=10 follows 0xFC.
  - Repeat with BYTE_ERROR_CODE=01 on the first reply, then 0xFA: required one resend, then status 00.
- BYTE_SENT never arrives, TIMEOUT_CYCLES=100.
  - Required: DONE with status 11 exactly 100 cycles after WAIT_SENT entry, and no retry.
  - Same cycle BYTE_READY(0xFA) and timeout: required status 00.
- RESET_N low during WAIT_ACK.
  - Required: all outputs return to reset values asynchronously and no DONE pulse occurs.
  - After release, a new REQ0 request completes normally.
